// File: rtl/ysyx_22041405_wbu.sv
// Write-back unit: retires one instruction at a time, fetching and aligning load data
// from data memory before driving the register-file write port and a commit pulse.
module ysyx_22041405_wbu #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic [ADDR_WIDTH-1:0] in_waddr,
  input  logic                  in_is_load,
  input  logic [2:0]            in_load_type,
  input  logic [WIDTH-1:0]      in_alu_result,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [WIDTH-1:0]      mem_raddr,
  input  logic                  mem_rsp_valid,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [WIDTH-1:0]      rf_wdata,
  output logic                  commit_valid,
  output logic                  load_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t                r_state;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [2:0]            r_load_type;
  logic [WIDTH-1:0]      r_addr;
  logic                  r_fault;
  logic                  r_in_ready;
  logic                  r_mem_req_valid;
  logic                  r_rf_wen;
  logic [ADDR_WIDTH-1:0] r_rf_waddr;
  logic [WIDTH-1:0]      r_rf_wdata;
  logic                  r_commit;
  logic                  r_load_fault;

  logic                  w_in_fault;
  logic [WIDTH-1:0]      w_shifted;
  logic [WIDTH-1:0]      w_ext;

  // Illegal funct3 or a misaligned halfword/word access never reaches memory.
  always_comb begin
    w_in_fault = 1'b0;
    case (in_load_type)
      3'b011, 3'b110, 3'b111: w_in_fault = 1'b1;
      3'b001, 3'b101:         w_in_fault = in_alu_result[0];
      3'b010:                 w_in_fault = |in_alu_result[1:0];
      default:                w_in_fault = 1'b0;
    endcase
  end

  // Shifting by the byte offset puts the addressed byte/halfword at bit 0.
  assign w_shifted = mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = '0;
    case (r_load_type)
      3'b000:  w_ext = {{(WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ext = {{(WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ext = {{(WIDTH-8){1'b0}}, w_shifted[7:0]};
      3'b101:  w_ext = {{(WIDTH-16){1'b0}}, w_shifted[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_wen           <= 1'b0;
      r_waddr         <= '0;
      r_load_type     <= '0;
      r_addr          <= '0;
      r_fault         <= 1'b0;
      r_in_ready      <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_rf_wen        <= 1'b0;
      r_rf_waddr      <= '0;
      r_rf_wdata      <= '0;
      r_commit        <= 1'b0;
      r_load_fault    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_wen       <= in_wen;
            r_waddr     <= in_waddr;
            r_load_type <= in_load_type;
            r_addr      <= in_alu_result;
            r_in_ready  <= 1'b0;
            if (!in_is_load) begin
              r_fault    <= 1'b0;
              r_state    <= WB;
              r_commit   <= 1'b1;
              r_rf_wen   <= in_wen && (in_waddr != '0);
              r_rf_waddr <= in_waddr;
              r_rf_wdata <= in_alu_result;
            end else if (w_in_fault) begin
              r_fault      <= 1'b1;
              r_state      <= WB;
              r_commit     <= 1'b1;
              r_load_fault <= 1'b1;
              r_rf_waddr   <= in_waddr;
            end else begin
              r_fault         <= 1'b0;
              r_state         <= REQ;
              r_mem_req_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_state         <= WAIT;
            r_mem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            r_state    <= WB;
            r_commit   <= 1'b1;
            r_rf_wen   <= r_wen && (r_waddr != '0) && !r_fault;
            r_rf_waddr <= r_waddr;
            r_rf_wdata <= w_ext;
          end
        end
        WB: begin
          r_state      <= IDLE;
          r_in_ready   <= 1'b1;
          r_commit     <= 1'b0;
          r_rf_wen     <= 1'b0;
          r_load_fault <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_raddr     = {r_addr[WIDTH-1:2], 2'b00};
  assign rf_wen        = r_rf_wen;
  assign rf_waddr      = r_rf_waddr;
  assign rf_wdata      = r_rf_wdata;
  assign commit_valid  = r_commit;
  assign load_fault    = r_load_fault;

endmodule

// File: tb/tb_ysyx_22041405_wbu.sv
// Directed bench for the write-back unit: ALU retire, aligned loads, faults, x0, reset abort.
module tb_ysyx_22041405_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [4:0]  in_waddr;
  logic        in_is_load;
  logic [2:0]  in_load_type;
  logic [31:0] in_alu_result;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_raddr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic        load_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22041405_wbu #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_waddr(in_waddr),
    .in_is_load(in_is_load), .in_load_type(in_load_type), .in_alu_result(in_alu_result),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_raddr(mem_raddr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .load_fault(load_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [4:0] waddr, input logic is_load,
                       input logic [2:0] ltype, input logic [31:0] alu);
    in_valid      = 1'b1;
    in_wen        = wen;
    in_waddr      = waddr;
    in_is_load    = is_load;
    in_load_type  = ltype;
    in_alu_result = alu;
    tick();
    in_valid      = 1'b0;
  endtask

  // Load with immediate grant; a stray response offered during REQ must be ignored.
  task automatic do_load(input string tag, input logic [4:0] waddr, input logic [2:0] ltype,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] exp_data);
    issue(1'b1, waddr, 1'b1, ltype, addr);
    chk({tag, "_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hDEAD_BEEF;
    tick();
    mem_req_ready = 1'b0;
    chk({tag, "_wait_no_commit"}, {31'd0, commit_valid}, 32'd0);
    mem_rdata     = rdata;
    tick();
    mem_rsp_valid = 1'b0;
    chk({tag, "_wdata"}, rf_wdata, exp_data);
    chk({tag, "_wen"}, {31'd0, rf_wen}, 32'd1);
    chk({tag, "_commit"}, {31'd0, commit_valid}, 32'd1);
    tick();
  endtask

  task automatic do_fault(input string tag, input logic [2:0] ltype, input logic [31:0] addr);
    issue(1'b1, 5'd3, 1'b1, ltype, addr);
    chk({tag, "_no_req"}, {31'd0, mem_req_valid}, 32'd0);
    chk({tag, "_fault"}, {31'd0, load_fault}, 32'd1);
    chk({tag, "_commit"}, {31'd0, commit_valid}, 32'd1);
    chk({tag, "_wen"}, {31'd0, rf_wen}, 32'd0);
    tick();
    chk({tag, "_fault_drop"}, {31'd0, load_fault}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_waddr = '0; in_is_load = 1'b0;
    in_load_type = '0; in_alu_result = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rdata = '0;
    tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_raddr", mem_raddr, 32'd0);
    chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_commit", {31'd0, commit_valid}, 32'd0);
    chk("rst_fault", {31'd0, load_fault}, 32'd0);
    rst = 1'b1;
    tick();

    issue(1'b1, 5'd5, 1'b0, 3'b000, 32'h0000_00AB);
    chk("alu_wen", {31'd0, rf_wen}, 32'd1);
    chk("alu_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("alu_wdata", rf_wdata, 32'h0000_00AB);
    chk("alu_commit", {31'd0, commit_valid}, 32'd1);
    chk("alu_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    chk("alu_ready_back", {31'd0, in_ready}, 32'd1);
    chk("alu_commit_drop", {31'd0, commit_valid}, 32'd0);
    chk("alu_wen_drop", {31'd0, rf_wen}, 32'd0);
    chk("alu_wdata_hold", rf_wdata, 32'h0000_00AB);

    // lb with the grant withheld for three cycles
    issue(1'b1, 5'd7, 1'b1, 3'b000, 32'h8000_0003);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("lb_req_held", {31'd0, mem_req_valid}, 32'd1);
      chk("lb_raddr", mem_raddr, 32'h8000_0000);
      chk("lb_ready_low", {31'd0, in_ready}, 32'd0);
      tick();
    end
    chk("lb_req_still", {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("lb_req_drop", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h80FF_1234;
    tick();
    mem_rsp_valid = 1'b0;
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lb_wen", {31'd0, rf_wen}, 32'd1);
    chk("lb_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("lb_commit", {31'd0, commit_valid}, 32'd1);
    tick();

    do_load("lhu", 5'd8, 3'b101, 32'h8000_0002, 32'hBEEF_1234, 32'h0000_BEEF);
    do_load("lh",  5'd8, 3'b001, 32'h8000_0002, 32'hBEEF_1234, 32'hFFFF_BEEF);
    do_load("lw",  5'd9, 3'b010, 32'h8000_0004, 32'h1234_5678, 32'h1234_5678);
    do_load("lbu", 5'd9, 3'b100, 32'h8000_0001, 32'h0000_A500, 32'h0000_00A5);
    do_load("lh_lo", 5'd10, 3'b001, 32'h8000_0000, 32'h0000_8001, 32'hFFFF_8001);

    do_fault("lw_mis", 3'b010, 32'h8000_0002);
    do_fault("type011", 3'b011, 32'h8000_0000);
    do_fault("lhu_odd", 3'b101, 32'h8000_0001);

    issue(1'b1, 5'd0, 1'b0, 3'b000, 32'h0000_1234);
    chk("x0_commit", {31'd0, commit_valid}, 32'd1);
    chk("x0_wen", {31'd0, rf_wen}, 32'd0);
    chk("x0_wdata", rf_wdata, 32'h0000_1234);
    tick();

    // reset while the load waits for its response
    issue(1'b1, 5'd4, 1'b1, 3'b010, 32'h8000_0010);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_wen", {31'd0, rf_wen}, 32'd0);
    chk("abort_commit", {31'd0, commit_valid}, 32'd0);
    chk("abort_wdata", rf_wdata, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    chk("stray_wen", {31'd0, rf_wen}, 32'd0);
    chk("stray_commit", {31'd0, commit_valid}, 32'd0);
    chk("stray_ready", {31'd0, in_ready}, 32'd1);
    issue(1'b1, 5'd9, 1'b0, 3'b000, 32'h0000_0055);
    chk("post_wen", {31'd0, rf_wen}, 32'd1);
    chk("post_waddr", {27'd0, rf_waddr}, 32'd9);
    chk("post_wdata", rf_wdata, 32'h0000_0055);
    chk("post_commit", {31'd0, commit_valid}, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22041405_wbu.md
Name: ysyx_22041405_wbu

Overview:
- Write-back unit: the writer side of the register file whose read ports the decode stage consumes.
- Accepts one retiring instruction per transaction over a valid/ready handshake: ALU result or load.
- For loads, issues a single word read to data memory, then aligns and extends the returned data.
- Drives the register-file write port (rf_waddr/rf_wdata/rf_wen) and a one-cycle commit pulse.

Parameters:
- WIDTH, 32, datapath/register width.
- ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream has an instruction to retire.
- in_ready  out  1  WBU can accept; high only in IDLE.
- in_wen  in  1  instruction writes rd.
- in_waddr  in  ADDR_WIDTH  rd index.
- in_is_load  in  1  instruction is a load.
- in_load_type  in  3  load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- in_alu_result  in  WIDTH  ALU result; the effective address for loads.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_raddr  out  WIDTH  word-aligned address {in_alu_result[31:2],2'b00}.
- mem_rsp_valid  in  1  read data valid.
- mem_rdata  in  WIDTH  read word.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  ADDR_WIDTH  write index.
- rf_wdata  out  WIDTH  write data.
- commit_valid  out  1  one-cycle pulse per retired instruction.
- load_fault  out  1  one-cycle pulse: misaligned or illegal load type.

Behaviour:
- Reset (rst==0 at clk edge):
  - State goes to IDLE.
  - All latched fields cleared.
  - Outputs then: in_ready=1, all other outputs 0.
  - Reset mid-transaction abandons it silently. A later mem_rsp_valid while IDLE is ignored.
- States: IDLE, REQ, WAIT, WB.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_wen, in_waddr, in_is_load, in_load_type and in_alu_result.
  - Non-load: go to WB.
  - Load with illegal type (011, 110, 111): go to WB with fault flag set.
  - Load misaligned (lh/lhu with addr[0]=1; lw with addr[1:0]!=0): go to WB with fault flag set.
  - Otherwise: go to REQ.
- REQ:
  - mem_req_valid=1; mem_raddr held stable from the latched address.
  - On mem_req_ready: go to WAIT.
  - mem_rsp_valid is ignored in REQ.
- WAIT:
  - On mem_rsp_valid: capture the extracted data and go to WB.
  - No timeout; waits indefinitely.
- Load data extraction, byte offset k = addr[1:0]:
  - lb/lbu: take byte mem_rdata[8k+7:8k]; sign- or zero-extend.
  - lh/lhu: take halfword selected by addr[1]; sign- or zero-extend.
  - lw: whole word.
- WB (exactly one cycle, then IDLE):
  - commit_valid=1.
  - rf_wen=1 only if latched wen=1 AND waddr!=0 AND fault flag=0.
  - load_fault=1 if fault flag is set.
  - rf_waddr/rf_wdata come from registers and are valid during WB.
  - rf_wdata = ALU result for non-loads, extracted data for loads.
- Outside WB: rf_wen=0, commit_valid=0, load_fault=0. rf_waddr/rf_wdata hold their last value.
- Latency:
  - ALU instruction accepted at edge T: WB during cycle T+1.
  - Load: REQ at T+1; earliest WAIT at T+2; earliest WB at T+3.
- Throughput: in_ready is low in REQ/WAIT/WB, so at most one instruction is in flight.
- Writes to x0 are never issued.

Test Plan:
- Reset release, then in_valid with in_wen=1, in_waddr=5, in_alu_result=0x0000_00AB, non-load -> WB one cycle later: rf_wen=1, rf_waddr=5, rf_wdata=0xAB, commit_valid=1; in_ready low for exactly one cycle.
- lb addr 0x8000_0003, mem_rdata=0x80FF_1234, mem_req_ready held low 3 cycles -> mem_req_valid held with mem_raddr=0x8000_0000; after response: rf_wdata=0xFFFF_FF80, rf_wen=1.
- lhu addr 0x8000_0002, mem_rdata=0xBEEF_1234 -> rf_wdata=0x0000_BEEF. Same access as lh -> rf_wdata=0xFFFF_BEEF.
- lw addr 0x8000_0002 -> no memory request; WB next cycle: load_fault=1, commit_valid=1, rf_wen=0. Also in_load_type=011 -> same response.
- in_waddr=0, in_wen=1, ALU result 0x1234 -> commit_valid=1, rf_wen=0.
- Load in WAIT, rst low one cycle -> IDLE, no rf_wen. A subsequent stray mem_rsp_valid is ignored. The next ALU instruction retires normally.
